// File: rtl/svm_pkg.sv
// Shared SVM constants and the loader state type, used by the loader,
// the support/alpha SRAM wrappers and the classifier.
package svm_pkg;

  localparam int SVM_NBITS      = 9;    // signed word width
  localparam int SVM_VSUP_WIDTH = 120;  // V-support words per row
  localparam int SVM_ASUP_WIDTH = 155;  // A-support words per row
  localparam int SVM_NSUP       = 214;  // rows per image
  localparam int SVM_NVALPHA    = 120;  // rows 0..119 carry a V alpha
  localparam int SVM_NAALPHA    = 155;  // rows 0..154 carry an A alpha
  localparam int SVM_ADDR_WIDTH = 8;    // ceil(log2(SVM_NSUP))
  localparam int SVM_ELEM_WIDTH = 8;    // per-phase word counter width

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_V  = 3'd1,
    LOAD_A  = 3'd2,
    LOAD_VA = 3'd3,
    LOAD_AA = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6
  } loader_state_e;

  // True in the states that accept stream words.
  function automatic logic is_load_state(input loader_state_e s);
    return (s == LOAD_V) || (s == LOAD_A) || (s == LOAD_VA) || (s == LOAD_AA);
  endfunction

endpackage

// File: rtl/svm_word_shifter.sv
// Enable-gated right-shift packer: each accepted word enters at the MSB end,
// so after DEPTH words the first one sits in bits [NBITS-1:0].
module svm_word_shifter #(
  parameter int NBITS = 9,
  parameter int DEPTH = 120
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic [NBITS-1:0]       i_word,
  output logic [NBITS*DEPTH-1:0] o_row
);

  logic [NBITS*DEPTH-1:0] r_row;

  // Shift the row one word to the right on every accepted word; never cleared between rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= {(NBITS*DEPTH){1'b0}};
    end else if (i_en) begin
      r_row <= {i_word, r_row[NBITS*DEPTH-1:NBITS]};
    end
  end

  assign o_row = r_row;

endmodule

// File: rtl/svm_memory_loader.sv
// Streams signed words into the SVM support/alpha SRAM bank: packs one row
// (V words, A words, optional V alpha, optional A alpha), then issues a single
// active-low write for that row. Forwards the consumer read address when idle.
module svm_memory_loader
  import svm_pkg::*;
#(
  parameter int NBITS      = SVM_NBITS,
  parameter int VSUP_WIDTH = SVM_VSUP_WIDTH,
  parameter int ASUP_WIDTH = SVM_ASUP_WIDTH,
  parameter int NSUP       = SVM_NSUP,
  parameter int NVALPHA    = SVM_NVALPHA,
  parameter int NAALPHA    = SVM_NAALPHA,
  parameter int ADDR_WIDTH = SVM_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NBITS-1:0]             in_data,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        addr,
  output logic                         we,
  output logic [NBITS*VSUP_WIDTH-1:0]  v_in_support,
  output logic [NBITS-1:0]             v_in_alpha,
  output logic [NBITS*ASUP_WIDTH-1:0]  a_in_support,
  output logic [NBITS-1:0]             a_in_alpha
);

  localparam logic [SVM_ELEM_WIDTH-1:0] LP_V_LAST   = SVM_ELEM_WIDTH'(VSUP_WIDTH - 1);
  localparam logic [SVM_ELEM_WIDTH-1:0] LP_A_LAST   = SVM_ELEM_WIDTH'(ASUP_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0]     LP_NVALPHA  = ADDR_WIDTH'(NVALPHA);
  localparam logic [ADDR_WIDTH-1:0]     LP_NAALPHA  = ADDR_WIDTH'(NAALPHA);
  localparam logic [ADDR_WIDTH-1:0]     LP_ROW_LAST = ADDR_WIDTH'(NSUP - 1);
  localparam logic [ADDR_WIDTH-1:0]     LP_ROW_ONE  = ADDR_WIDTH'(1);
  localparam logic [SVM_ELEM_WIDTH-1:0] LP_ELEM_ONE = SVM_ELEM_WIDTH'(1);

  loader_state_e               r_state;
  logic [ADDR_WIDTH-1:0]       r_row;
  logic [SVM_ELEM_WIDTH-1:0]   r_elem;
  logic                        r_in_ready;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_we;
  logic [NBITS-1:0]            r_v_alpha;
  logic [NBITS-1:0]            r_a_alpha;

  logic                        w_xfer;
  logic                        w_v_en;
  logic                        w_a_en;
  logic [ADDR_WIDTH-1:0]       w_addr;

  // in_ready is only ever high in LOAD_* states, so a transfer implies a load state.
  assign w_xfer = in_valid & r_in_ready;
  assign w_v_en = w_xfer & (r_state == LOAD_V);
  assign w_a_en = w_xfer & (r_state == LOAD_A);

  svm_word_shifter #(
    .NBITS (NBITS),
    .DEPTH (VSUP_WIDTH)
  ) u_v_shifter (
    .clk    (clk),
    .rst_n  (rst),
    .i_en   (w_v_en),
    .i_word (in_data),
    .o_row  (v_in_support)
  );

  svm_word_shifter #(
    .NBITS (NBITS),
    .DEPTH (ASUP_WIDTH)
  ) u_a_shifter (
    .clk    (clk),
    .rst_n  (rst),
    .i_en   (w_a_en),
    .i_word (in_data),
    .o_row  (a_in_support)
  );

  // Alpha words load directly; they keep their last value for rows without an alpha.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v_alpha <= {NBITS{1'b0}};
      r_a_alpha <= {NBITS{1'b0}};
    end else if (w_xfer && (r_state == LOAD_VA)) begin
      r_v_alpha <= in_data;
    end else if (w_xfer && (r_state == LOAD_AA)) begin
      r_a_alpha <= in_data;
    end
  end

  // Loader FSM with its counters and registered handshake/status/write-enable outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_row      <= {ADDR_WIDTH{1'b0}};
      r_elem     <= {SVM_ELEM_WIDTH{1'b0}};
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_we       <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= LOAD_V;
            r_row      <= {ADDR_WIDTH{1'b0}};
            r_elem     <= {SVM_ELEM_WIDTH{1'b0}};
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        LOAD_V: begin
          if (w_xfer) begin
            if (r_elem == LP_V_LAST) begin
              r_elem  <= {SVM_ELEM_WIDTH{1'b0}};
              r_state <= LOAD_A;
            end else begin
              r_elem <= r_elem + LP_ELEM_ONE;
            end
          end
        end
        LOAD_A: begin
          if (w_xfer) begin
            if (r_elem == LP_A_LAST) begin
              r_elem <= {SVM_ELEM_WIDTH{1'b0}};
              if (r_row < LP_NVALPHA) begin
                r_state <= LOAD_VA;
              end else if (r_row < LP_NAALPHA) begin
                r_state <= LOAD_AA;
              end else begin
                r_state    <= WRITE;
                r_in_ready <= 1'b0;
                r_we       <= 1'b0;
              end
            end else begin
              r_elem <= r_elem + LP_ELEM_ONE;
            end
          end
        end
        LOAD_VA: begin
          if (w_xfer) begin
            if (r_row < LP_NAALPHA) begin
              r_state <= LOAD_AA;
            end else begin
              r_state    <= WRITE;
              r_in_ready <= 1'b0;
              r_we       <= 1'b0;
            end
          end
        end
        LOAD_AA: begin
          if (w_xfer) begin
            r_state    <= WRITE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
          end
        end
        WRITE: begin
          r_we  <= 1'b1;
          r_row <= r_row + LP_ROW_ONE;
          if (r_row == LP_ROW_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= LOAD_V;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_row      <= {ADDR_WIDTH{1'b0}};
          r_elem     <= {SVM_ELEM_WIDTH{1'b0}};
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_we       <= 1'b1;
        end
      endcase
    end
  end

  // Memory address: row counter during a load, consumer read address otherwise.
  always_comb begin
    w_addr = rd_addr;
    if (r_busy) begin
      w_addr = r_row;
    end else begin
      w_addr = rd_addr;
    end
  end

  assign addr       = w_addr;
  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign we         = r_we;
  assign v_in_alpha = r_v_alpha;
  assign a_in_alpha = r_a_alpha;

endmodule

// File: tb/tb_svm_memory_loader.sv
// Randomised bench for svm_memory_loader: drives word streams with random
// valid gaps, captures every active-low write into an SRAM image and compares
// it with rows computed directly from the stream layout rules.
module tb_svm_memory_loader;

  localparam int NB  = 9;
  localparam int VW  = 120;
  localparam int AW  = 155;
  localparam int NS  = 214;
  localparam int NVA = 120;
  localparam int NAA = 155;
  localparam int AWD = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [NB-1:0]     in_data;
  logic [AWD-1:0]    rd_addr;
  logic              busy;
  logic              done;
  logic [AWD-1:0]    addr;
  logic              we;
  logic [NB*VW-1:0]  v_in_support;
  logic [NB-1:0]     v_in_alpha;
  logic [NB*AW-1:0]  a_in_support;
  logic [NB-1:0]     a_in_alpha;

  svm_memory_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .rd_addr      (rd_addr),
    .busy         (busy),
    .done         (done),
    .addr         (addr),
    .we           (we),
    .v_in_support (v_in_support),
    .v_in_alpha   (v_in_alpha),
    .a_in_support (a_in_support),
    .a_in_alpha   (a_in_alpha)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stream of the current load and how many of its words were consumed.
  logic [NB-1:0] stream[$];
  int            idx;
  int            row_end[NS];     // cumulative word count at the end of each row

  // Captured SRAM writes.
  logic [NB*VW-1:0] cap_v[NS];
  logic [NB*AW-1:0] cap_a[NS];
  logic [NB-1:0]    cap_va[NS];
  logic [NB-1:0]    cap_aa[NS];
  int               cap_idx[NS];
  int               wr_count;
  int               wr_bad;
  int               ready_viol;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int row_len(input int r);
    return VW + AW + ((r < NVA) ? 1 : 0) + ((r < NAA) ? 1 : 0);
  endfunction

  task automatic clear_capture();
    for (int r = 0; r < NS; r++) begin
      cap_v[r]   = '0;
      cap_a[r]   = '0;
      cap_va[r]  = '0;
      cap_aa[r]  = '0;
      cap_idx[r] = 0;
    end
    wr_count   = 0;
    wr_bad     = 0;
    ready_viol = 0;
    idx        = 0;
  endtask

  task automatic make_stream(input bit counting);
    int total;
    total = row_end[NS-1];
    stream.delete();
    for (int k = 0; k < total; k++) begin
      if (counting) stream.push_back(NB'(k % 256));
      else          stream.push_back(NB'($urandom));
    end
  endtask

  // Expected rows rebuilt from the stream layout; counts rows that disagree with the capture.
  task automatic verify_image(input string tag, input int nrows);
    logic [NB*VW-1:0] exp_v;
    logic [NB*AW-1:0] exp_a;
    logic [NB-1:0]    lva;
    logic [NB-1:0]    laa;
    int off;
    int p;
    int bad;
    off = 0;
    bad = 0;
    lva = '0;
    laa = '0;
    for (int r = 0; r < nrows; r++) begin
      for (int i = 0; i < VW; i++) exp_v[NB*i +: NB] = stream[off + i];
      for (int j = 0; j < AW; j++) exp_a[NB*j +: NB] = stream[off + VW + j];
      p = off + VW + AW;
      if (r < NVA) begin lva = stream[p]; p++; end
      if (r < NAA) begin laa = stream[p]; p++; end
      if (cap_v[r] !== exp_v || cap_a[r] !== exp_a || cap_va[r] !== lva || cap_aa[r] !== laa)
        bad++;
      off = p;
    end
    check_eq({tag, "_rows_bad"}, bad, 0);
    check_eq({tag, "_write_order_bad"}, wr_bad, 0);
    check_eq({tag, "_ready_vs_we"}, ready_viol, 0);
  endtask

  // Per-cycle driver/monitor: observes outputs at negedge, then drives the next cycle's inputs.
  task automatic run_stream(input int slow_words, input int start_pulse_at, input int stop_idx,
                            input int stop_writes, input int max_cycles, input string tag);
    int cyc;
    bit stop;
    int pct;
    cyc  = 0;
    stop = 1'b0;
    while (!stop) begin
      @(negedge clk);
      if (busy === 1'b1 && in_ready !== we) ready_viol++;
      if (we === 1'b0) begin
        if (wr_count >= NS) wr_bad++;
        else if (int'(addr) != wr_count || idx != row_end[wr_count]) wr_bad++;
        if (int'(addr) < NS) begin
          cap_v[addr]   = v_in_support;
          cap_a[addr]   = a_in_support;
          cap_va[addr]  = v_in_alpha;
          cap_aa[addr]  = a_in_alpha;
          cap_idx[addr] = idx;
        end
        wr_count++;
      end
      cyc++;
      if ((stop_writes > 0 && wr_count >= stop_writes) || (stop_idx > 0 && idx >= stop_idx)) begin
        stop = 1'b1;
      end else if (cyc >= max_cycles) begin
        stop = 1'b1;
        if (stop_writes > 0) check_eq({tag, "_timeout_writes"}, wr_count, stop_writes);
        else                 check_eq({tag, "_timeout_words"}, idx, stop_idx);
      end
      if (stop) begin
        in_valid = 1'b0;
        start    = 1'b0;
      end else begin
        start    = (cyc == start_pulse_at);
        pct      = (idx < slow_words) ? 50 : 100;
        in_valid = (idx < stream.size()) && ($urandom_range(99, 0) < pct);
        in_data  = in_valid ? stream[idx] : NB'($urandom);
        if (in_valid && in_ready) idx++;
      end
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_done_clr"}, done, 0);
    check_eq({tag, "_ready"}, in_ready, 1);
    check_eq({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    int acc;
    acc = 0;
    for (int r = 0; r < NS; r++) begin
      acc += row_len(r);
      row_end[r] = acc;
    end

    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rd_addr  = 8'd37;
    clear_capture();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_we", we, 1);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_addr", addr, 37);
    check_eq("rst_valpha", v_in_alpha, 0);
    rst = 1'b1;

    // Idle pass-through of the read address
    @(negedge clk);
    rd_addr = 8'd37;
    #1;
    check_eq("idle_addr37", addr, 37);
    check_eq("idle_we", we, 1);
    rd_addr = 8'd200;
    #1;
    check_eq("idle_addr200", addr, 200);
    check_eq("idle_ready", in_ready, 0);

    // Reset in the middle of row 3's A phase
    make_stream(1'b0);
    do_start("start1");
    run_stream(1000000, -1, row_end[2] + VW + 20, 0, 20000, "midload");
    check_eq("pre_reset_writes", wr_count, 3);
    verify_image("pre_reset", 3);
    rst = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_we", we, 1);
    check_eq("abort_ready", in_ready, 0);
    check_eq("abort_vsup_zero", {63'd0, |v_in_support}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Full load with counting words, backpressure early, ignored start pulse mid-load
    clear_capture();
    make_stream(1'b1);
    rd_addr = 8'd99;
    do_start("start2");
    run_stream(2000, 3000, 0, NS, 80000, "full");
    check_eq("full_writes", wr_count, NS);
    check_eq("full_last_write_done_low", done, 0);
    verify_image("full", NS);
    check_eq("row0_v0", cap_v[0][8:0], 0);
    check_eq("row0_v119", cap_v[0][NB*119 +: NB], 119);
    check_eq("row0_a0", cap_a[0][8:0], 120);
    check_eq("row0_a154", cap_a[0][NB*154 +: NB], 18);
    check_eq("row0_valpha", cap_va[0], 19);
    check_eq("row0_aalpha", cap_aa[0], 20);
    check_eq("row119_len", cap_idx[119] - cap_idx[118], 277);
    check_eq("row120_len", cap_idx[120] - cap_idx[119], 276);
    check_eq("row155_len", cap_idx[155] - cap_idx[154], 275);
    check_eq("row213_end", cap_idx[213], 59125);
    @(negedge clk);
    check_eq("done_set", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_we", we, 1);
    check_eq("done_ready", in_ready, 0);
    check_eq("done_addr", addr, 99);
    repeat (5) @(negedge clk);
    check_eq("done_hold", done, 1);

    // Restart from DONE with random words
    clear_capture();
    make_stream(1'b0);
    do_start("restart");
    run_stream(1000000, -1, 0, 1, 2000, "restart");
    check_eq("restart_first_addr_words", cap_idx[0], 277);
    verify_image("restart", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
